rmem_column_packer: RTL and testbench

RMEM_COLUMN_PACKER -- requirements
Module: rmem_column_packer

---
 rtl/rmem_pkg.sv | 31 +++
 rtl/rmem_byte_aligner.sv | 36 +++
 rtl/rmem_column_packer.sv | 241 ++++++++++++++++++++++++
 tb/tb_rmem_column_packer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmem_pkg.sv
// Shared types and constants for the row-memory column packer:
// FSM state encoding, column-width codes and the row-length limit.
package rmem_pkg;

  localparam int C_MAX_ROW_WORDS = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] CW_1B  = 2'd0;
  localparam logic [1:0] CW_2B  = 2'd1;
  localparam logic [1:0] CW_4B  = 2'd2;
  localparam logic [1:0] CW_ILL = 2'd3;

  // Column width code to byte count; the illegal code maps to zero bytes.
  function automatic logic [2:0] width_bytes(input logic [1:0] cw);
    logic [2:0] n;
    case (cw)
      CW_1B:   n = 3'd1;
      CW_2B:   n = 3'd2;
      CW_4B:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rmem_byte_aligner.sv
// Combinational column extraction: selects the column bytes from a beat and
// merges them above the bytes already held in the pack register.
module rmem_byte_aligner
  import rmem_pkg::*;
(
  input  logic [31:0] s_data,
  input  logic [1:0]  col_offset,
  input  logic [1:0]  col_width,
  input  logic [31:0] pack_in,
  input  logic [1:0]  fill_in,
  output logic [31:0] word_out,
  output logic [31:0] carry_out,
  output logic [2:0]  total_out
);

  logic [31:0] shifted_s;
  logic [31:0] mask_s;
  logic [63:0] merged_s;

  // Byte-select, shift to the current fill level and merge; bytes past the
  // low word spill into the carry half.
  always_comb begin
    shifted_s = s_data >> {col_offset, 3'b000};
    case (col_width)
      CW_1B:   mask_s = 32'h0000_00FF;
      CW_2B:   mask_s = 32'h0000_FFFF;
      CW_4B:   mask_s = 32'hFFFF_FFFF;
      default: mask_s = 32'h0000_0000;
    endcase
    merged_s  = {32'd0, pack_in} | ({32'd0, shifted_s & mask_s} << {fill_in, 3'b000});
    word_out  = merged_s[31:0];
    carry_out = merged_s[63:32];
    total_out = {1'b0, fill_in} + width_bytes(col_width);
  end

endmodule

// File: rtl/rmem_column_packer.sv
// Extracts one column from a row-major read-data stream and packs the column
// bytes densely into 32-bit little-endian output words.
module rmem_column_packer #(
  parameter int C_DATA_WIDTH    = 32,
  parameter int C_MAX_ROW_WORDS = rmem_pkg::C_MAX_ROW_WORDS
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic [4:0]              row_words,
  input  logic [3:0]              col_word,
  input  logic [1:0]              col_offset,
  input  logic [1:0]              col_width,
  input  logic [15:0]             row_count,
  input  logic [C_DATA_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  output logic [C_DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);
  import rmem_pkg::*;

  localparam logic [5:0] MAX_RW = 6'(C_MAX_ROW_WORDS);

  state_e            state_q, state_d;
  logic [4:0]        rw_q, rw_d;
  logic [3:0]        cw_q, cw_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        wid_q, wid_d;
  logic [15:0]       rc_q, rc_d;
  logic [4:0]        word_cnt_q, word_cnt_d;
  logic [15:0]       row_cnt_q, row_cnt_d;
  logic [31:0]       pack_q, pack_d;
  logic [1:0]        fill_q, fill_d;
  logic [C_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              s_ready_s;
  logic              s_fire_s;
  logic              col_hit_s;
  logic              row_end_s;
  logic              last_row_s;
  logic              cfg_bad_s;
  logic [31:0]       al_word_s;
  logic [31:0]       al_carry_s;
  logic [2:0]        al_total_s;
  logic              unused_s;

  // Row framing comes from the counters; s_last only marks burst boundaries.
  assign unused_s = s_last;

  rmem_byte_aligner u_aligner (
    .s_data     (s_data),
    .col_offset (off_q),
    .col_width  (wid_q),
    .pack_in    (pack_q),
    .fill_in    (fill_q),
    .word_out   (al_word_s),
    .carry_out  (al_carry_s),
    .total_out  (al_total_s)
  );

  // Handshake qualifiers, position decode and configuration legality.
  always_comb begin
    s_ready_s  = (state_q == S_RUN) && !(m_valid_q && !m_ready);
    s_fire_s   = s_ready_s && s_valid;
    col_hit_s  = (word_cnt_q == {1'b0, cw_q});
    row_end_s  = (word_cnt_q == (rw_q - 5'd1));
    last_row_s = (row_cnt_q == (rc_q - 16'd1));
    cfg_bad_s  = (col_width == CW_ILL)
              || (({1'b0, col_offset} + width_bytes(col_width)) > 3'd4)
              || ({1'b0, col_word} >= row_words)
              || (row_words == 5'd0)
              || ({1'b0, row_words} > MAX_RW)
              || (row_count == 16'd0);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    cw_d       = cw_q;
    off_d      = off_q;
    wid_d      = wid_q;
    rc_d       = rc_q;
    word_cnt_d = word_cnt_q;
    row_cnt_d  = row_cnt_q;
    pack_d     = pack_q;
    fill_d     = fill_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rw_d       = row_words;
          cw_d       = col_word;
          off_d      = col_offset;
          wid_d      = col_width;
          rc_d       = row_count;
          word_cnt_d = 5'd0;
          row_cnt_d  = 16'd0;
          pack_d     = 32'd0;
          fill_d     = 2'd0;
          error_d    = cfg_bad_s;
          state_d    = cfg_bad_s ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end else begin
          m_valid_d = m_valid_q;
        end
        if (s_fire_s) begin
          if (col_hit_s) begin
            // Total is 0..7 bytes; bit 2 flags a full word and the low bits
            // are the fill left over after it.
            if (al_total_s[2]) begin
              m_data_d  = al_word_s;
              m_valid_d = 1'b1;
              m_last_d  = last_row_s && (al_total_s[1:0] == 2'd0);
              pack_d    = al_carry_s;
            end else begin
              pack_d    = al_word_s;
            end
            fill_d = al_total_s[1:0];
          end else begin
            fill_d = fill_q;
          end
          if (row_end_s) begin
            word_cnt_d = 5'd0;
            row_cnt_d  = row_cnt_q + 16'd1;
            state_d    = last_row_s ? S_FLUSH : S_RUN;
          end else begin
            word_cnt_d = word_cnt_q + 5'd1;
          end
        end else begin
          word_cnt_d = word_cnt_q;
        end
      end

      S_FLUSH: begin
        if (fill_q != 2'd0) begin
          if (!m_valid_q || m_ready) begin
            m_data_d  = pack_q;
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            pack_d    = 32'd0;
            fill_d    = 2'd0;
          end else begin
            m_valid_d = m_valid_q;
          end
        end else if (!m_valid_q) begin
          state_d = S_DONE;
        end else if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = S_DONE;
        end else begin
          state_d = S_FLUSH;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, configuration, datapath and status registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      rw_q       <= 5'd0;
      cw_q       <= 4'd0;
      off_q      <= 2'd0;
      wid_q      <= 2'd0;
      rc_q       <= 16'd0;
      word_cnt_q <= 5'd0;
      row_cnt_q  <= 16'd0;
      pack_q     <= 32'd0;
      fill_q     <= 2'd0;
      m_data_q   <= {C_DATA_WIDTH{1'b0}};
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      cw_q       <= cw_d;
      off_q      <= off_d;
      wid_q      <= wid_d;
      rc_q       <= rc_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      pack_q     <= pack_d;
      fill_q     <= fill_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign s_ready = s_ready_s;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_rmem_column_packer.sv
// Scoreboard bench for rmem_column_packer: directed jobs push hand-computed
// output words; a monitor pops and compares on every output handshake.
module tb_rmem_column_packer;
  import rmem_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        start;
  logic [4:0]  row_words;
  logic [3:0]  col_word;
  logic [1:0]  col_offset;
  logic [1:0]  col_width;
  logic [15:0] row_count;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        error;

  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;

  rmem_column_packer #(.C_DATA_WIDTH(32), .C_MAX_ROW_WORDS(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .row_words(row_words),
    .col_word(col_word), .col_offset(col_offset), .col_width(col_width),
    .row_count(row_count), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done), .error(error)
  );

  always #5 ACLK = ~ACLK;

  // Output monitor: every handshake must match the head of the scoreboard.
  always @(negedge ACLK) begin
    if (ARESETN && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got data=%08h last=%0b, expected no output", m_data, m_last);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({m_last, m_data} !== mon_exp) begin
          errors++;
          $display("FAIL out_word: got data=%08h last=%0b, expected data=%08h last=%0b",
                   m_data, m_last, mon_exp[31:0], mon_exp[32]);
        end
      end
    end
    if (ARESETN && done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_val(input int pat, input int row, input int word);
    logic [7:0] r8;
    logic [7:0] w8;
    r8 = 8'(row);
    w8 = 8'(word);
    if (pat == 0) return 32'(row * 16 + word);
    return {r8 ^ 8'h5A, 8'hA0 + r8, w8, 8'(row * 16 + word)};
  endfunction

  // Called at the drive phase (#1 after a rising edge); returns there too.
  task automatic start_job(input logic [4:0] rw, input logic [3:0] cw, input logic [1:0] off,
                           input logic [1:0] wid, input logic [15:0] rc);
    row_words  = rw;
    col_word   = cw;
    col_offset = off;
    col_width  = wid;
    row_count  = rc;
    start      = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int g;
    g       = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge ACLK);
    while (!s_ready && g < 200) begin
      g++;
      @(negedge ACLK);
    end
    if (g >= 200) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: got s_ready=0 for 200 cycles, expected 1 for beat %08h", d);
    end
    @(posedge ACLK); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_rows(input int rw, input int rc, input int pat);
    for (int r = 0; r < rc; r++)
      for (int w = 0; w < rw; w++)
        send_beat(beat_val(pat, r, w), (w == rw - 1));
  endtask

  task automatic wait_done(input string name);
    int base;
    int g;
    base = done_cnt;
    g    = 0;
    @(negedge ACLK);
    while (!done && g < 400) begin
      g++;
      @(negedge ACLK);
    end
    chk({name, "_done_seen"}, 64'(done), 64'd1);
    repeat (3) @(negedge ACLK);
    chk({name, "_done_once"}, 64'(done_cnt - base), 64'd1);
    chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle"}, 64'(busy), 64'd0);
    @(posedge ACLK); #1;
  endtask

  task automatic test_stall();
    fork
      send_rows(3, 2, 1);
      begin : stall_chk
        int g;
        g = 0;
        @(negedge ACLK);
        while (!m_valid && g < 100) begin
          g++;
          @(negedge ACLK);
        end
        chk("stall_valid", 64'(m_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
          chk("stall_s_ready", 64'(s_ready), 64'd0);
          chk("stall_m_data", 64'(m_data), 64'hA101A001);
          @(negedge ACLK);
        end
        @(posedge ACLK); #1;
        m_ready = 1'b1;
      end
    join
  endtask

  initial begin
    int base;
    ARESETN = 1'b0; start = 1'b0; row_words = 5'd0; col_word = 4'd0;
    col_offset = 2'd0; col_width = 2'd0; row_count = 16'd0;
    s_data = 32'd0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;

    repeat (3) @(negedge ACLK);
    chk("reset_flags", 64'({m_valid, m_last, s_ready, busy, done, error}), 64'd0);
    chk("reset_m_data", 64'(m_data), 64'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Whole-word column: row*16+word, column at word 1.
    exp_q.push_back({1'b0, 32'h0000_0001});
    exp_q.push_back({1'b0, 32'h0000_0011});
    exp_q.push_back({1'b1, 32'h0000_0021});
    start_job(5'd4, 4'd1, 2'd0, CW_4B, 16'd3);
    chk("w4_busy", 64'(busy), 64'd1);
    send_rows(4, 3, 0);
    wait_done("w4");
    chk("w4_error", 64'(error), 64'd0);

    // Single-byte column at offset 2, partial final word zero-padded.
    exp_q.push_back({1'b0, 32'hA3A2_A1A0});
    exp_q.push_back({1'b1, 32'h0000_00A4});
    start_job(5'd2, 4'd1, 2'd2, CW_1B, 16'd5);
    send_rows(2, 5, 1);
    wait_done("w1");

    // Output back-pressure holds the word and stalls input.
    exp_q.push_back({1'b1, 32'hA101_A001});
    m_ready = 1'b0;
    start_job(5'd3, 4'd1, 2'd1, CW_2B, 16'd2);
    test_stall();
    wait_done("stall");

    // Illegal configuration: offset 3 with a 2-byte column.
    base    = done_cnt;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    start_job(5'd4, 4'd1, 2'd3, CW_2B, 16'd3);
    @(negedge ACLK);
    chk("bad_done", 64'(done), 64'd1);
    chk("bad_error", 64'(error), 64'd1);
    chk("bad_s_ready", 64'(s_ready), 64'd0);
    repeat (3) @(negedge ACLK);
    chk("bad_s_ready_idle", 64'(s_ready), 64'd0);
    chk("bad_done_once", 64'(done_cnt - base), 64'd1);
    chk("bad_error_sticky", 64'(error), 64'd1);
    @(posedge ACLK); #1;
    s_valid = 1'b0;

    // Two-byte column with carry across words; a mid-job start is ignored.
    exp_q.push_back({1'b0, 32'h5BA1_5AA0});
    exp_q.push_back({1'b0, 32'h59A3_58A2});
    exp_q.push_back({1'b1, 32'h0000_5EA4});
    start_job(5'd3, 4'd2, 2'd2, CW_2B, 16'd5);
    chk("w2_error_cleared", 64'(error), 64'd0);
    send_rows(3, 1, 1);
    col_width = CW_ILL;
    start     = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    chk("busy_start_ignored", 64'({busy, error}), 64'b10);
    for (int r = 1; r < 5; r++)
      for (int w = 0; w < 3; w++)
        send_beat(beat_val(1, r, w), (w == 2));
    wait_done("w2");

    // Reset mid-job after 2 of 4 rows with an output word pending.
    exp_q.push_back({1'b0, 32'h5AA0_0101});
    start_job(5'd2, 4'd1, 2'd0, CW_4B, 16'd4);
    send_rows(2, 2, 1);
    m_ready = 1'b0;
    @(negedge ACLK);
    chk("pre_rst_word", 64'({m_valid, m_last, busy, m_data}), {29'd0, 3'b101, 32'h5BA1_0111});
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    base    = done_cnt;
    #1;
    chk("rst_flags", 64'({m_valid, m_last, s_ready, busy, done, error}), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    repeat (3) @(negedge ACLK);
    chk("rst_no_done", 64'(done_cnt - base), 64'd0);
    chk("rst_sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    m_ready = 1'b1;

    // Single-word job right after reset: one-cycle latency, m_last set.
    exp_q.push_back({1'b1, 32'h5AA0_0000});
    start_job(5'd1, 4'd0, 2'd0, CW_4B, 16'd1);
    send_beat(beat_val(1, 0, 0), 1'b1);
    @(negedge ACLK);
    chk("lat1_word", 64'({m_valid, m_last, m_data}), {30'd0, 2'b11, 32'h5AA0_0000});
    wait_done("lat1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
